// File: rtl/piso_arbiter_if.sv
// Two-requester byte handshake plus the serialised frame outputs of piso_arbiter.
// slave is the arbiter side, master is the requester/observer side.
interface piso_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       frame_start;
    logic       done;
    logic       grant_id;
    logic       busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready,
        output ser_out, ser_valid, frame_start, done, grant_id, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready,
        input  ser_out, ser_valid, frame_start, done, grant_id, busy
    );
endinterface

// File: rtl/piso_arbiter.sv
// Round-robin arbiter between two byte requesters feeding a parallel-in/serial-out
// shifter: one byte per frame, 8 serial bits, then an optional idle gap.
module piso_arbiter #(
    parameter int GAP_CYCLES = 1,
    parameter bit LSB_FIRST  = 1
) (
    input  logic        clk,
    input  logic        rst,
    piso_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [3:0] gap_cnt;
    logic       last_grant;
    logic       grant_q;

    logic       any_valid;
    logic       winner;
    logic       accept;
    logic       in_shift;
    logic       ser_bit;
    logic [7:0] winner_data;

    // Contention goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            winner = ~last_grant;
        else
            winner = bus.req1_valid;
        winner_data = winner ? bus.req1_data : bus.req0_data;
    end

    // Next state and all frame outputs; everything is forced low while rst is held.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_shift  = 1'b0;
        ser_bit   = 1'b0;

        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                in_shift = 1'b1;
                if (bit_cnt == 3'd7)
                    state_nxt = HAS_GAP ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (LSB_FIRST)
            ser_bit = shift_reg[bit_cnt];
        else
            ser_bit = shift_reg[3'd7 - bit_cnt];

        if (rst) begin
            accept   = 1'b0;
            in_shift = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Accepted byte is latched here, so requesters are free the cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            gap_cnt    <= 4'd0;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        shift_reg  <= winner_data;
                        bit_cnt    <= 3'd0;
                        last_grant <= winner;
                        grant_q    <= winner;
                    end
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    gap_cnt <= 4'd0;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: begin
                    bit_cnt <= 3'd0;
                    gap_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign bus.req0_ready  = accept & ~winner;
    assign bus.req1_ready  = accept &  winner;
    assign bus.ser_valid   = in_shift;
    assign bus.ser_out     = in_shift & ser_bit;
    assign bus.frame_start = in_shift & (bit_cnt == 3'd0);
    assign bus.done        = in_shift & (bit_cnt == 3'd7);
    assign bus.grant_id    = grant_q;
    assign bus.busy        = (state != IDLE) & ~rst;

endmodule

// File: tb/tb_piso_arbiter.sv
// Directed bench for piso_arbiter: a per-cycle vector table for a single frame,
// plus hand sequences for contention, MSB-first, zero gap and mid-frame reset.
module tb_piso_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piso_arbiter_if m_if ();
    piso_arbiter_if msb_if ();
    piso_arbiter_if g0_if ();

    piso_arbiter #(.GAP_CYCLES(1), .LSB_FIRST(1)) u_dut  (.clk(clk), .rst(rst), .bus(m_if));
    piso_arbiter #(.GAP_CYCLES(1), .LSB_FIRST(0)) u_msb  (.clk(clk), .rst(rst), .bus(msb_if));
    piso_arbiter #(.GAP_CYCLES(0), .LSB_FIRST(1)) u_gap0 (.clk(clk), .rst(rst), .bus(g0_if));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {ready0, ready1, ser_out, ser_valid, frame_start, done, busy, grant_id}
    function automatic logic [7:0] obs_m();
        return {m_if.req0_ready, m_if.req1_ready, m_if.ser_out, m_if.ser_valid,
                m_if.frame_start, m_if.done, m_if.busy, m_if.grant_id};
    endfunction

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic idle_all();
        m_if.req0_valid   = 1'b0; m_if.req0_data   = 8'h00;
        m_if.req1_valid   = 1'b0; m_if.req1_data   = 8'h00;
        msb_if.req0_valid = 1'b0; msb_if.req0_data = 8'h00;
        msb_if.req1_valid = 1'b0; msb_if.req1_data = 8'h00;
        g0_if.req0_valid  = 1'b0; g0_if.req0_data  = 8'h00;
        g0_if.req1_valid  = 1'b0; g0_if.req1_data  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc, n_done, both, low, nd, sv_cnt;
        int acc_cyc [4];
        logic acc_id [4];
        logic [7:0] got [4];
        logic gid [4];
        logic [7:0] rx, seq;

        idle_all();
        rst = 1'b1;

        // ---------------- reset behaviour ----------------
        repeat (2) @(negedge clk);
        m_if.req0_valid = 1'b1;
        m_if.req1_valid = 1'b1;
        #1;
        chk("rst_ready0",    m_if.req0_ready, 0);
        chk("rst_ready1",    m_if.req1_ready, 0);
        chk("rst_busy",      m_if.busy,       0);
        chk("rst_ser_valid", m_if.ser_valid,  0);
        @(negedge clk);
        rst = 1'b0;
        m_if.req0_valid = 1'b0;
        m_if.req1_valid = 1'b0;
        #1;
        chk("rst_grant_id", m_if.grant_id, 0);
        chk("rst_idle_busy", m_if.busy, 0);

        // ---------------- contention, both valid ----------------
        do_reset();
        n_acc = 0; n_done = 0; both = 0; rx = 8'h00;
        for (int k = 0; k < 4; k++) begin
            acc_cyc[k] = -100; acc_id[k] = 1'bx; got[k] = 8'hxx; gid[k] = 1'bx;
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 0) begin
                m_if.req0_valid = 1'b1; m_if.req0_data = 8'h0F;
                m_if.req1_valid = 1'b1; m_if.req1_data = 8'hF0;
            end
            #1;
            if (m_if.req0_ready && m_if.req1_ready) both++;
            if (m_if.req0_ready || m_if.req1_ready) begin
                if (n_acc < 4) begin
                    acc_cyc[n_acc] = c;
                    acc_id[n_acc]  = m_if.req1_ready;
                end
                n_acc++;
            end
            if (m_if.ser_valid) rx = {m_if.ser_out, rx[7:1]};
            if (m_if.done && n_done < 4) begin
                got[n_done] = rx;
                gid[n_done] = m_if.grant_id;
                n_done++;
            end
        end
        idle_all();
        chk("cont_enough_accepts", n_acc >= 4, 1);
        chk("cont_never_both_ready", both, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cont_winner%0d", k), acc_id[k], k % 2);
            chk($sformatf("cont_byte%0d", k), got[k], (k % 2) ? 8'hF0 : 8'h0F);
            chk($sformatf("cont_grant_id%0d", k), gid[k], k % 2);
        end
        for (int k = 1; k < 4; k++)
            chk($sformatf("cont_spacing%0d", k), acc_cyc[k] - acc_cyc[k-1], 10);

        // ---------------- single frame 0xA5, vector table ----------------
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 8'b1000_0000};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'b0011_1010};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'b0001_0010};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'b0011_0010};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 8'h33, 8'b0001_0010};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h33, 8'b0001_0010};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'b0011_0010};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'b0001_0010};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'b0011_0110};
        tbl[9]  = '{1'b1, 8'h55, 1'b0, 8'h00, 8'b0000_0010};
        tbl[10] = '{1'b0, 8'h55, 1'b0, 8'h00, 8'b0000_0000};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'b0000_0000};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            m_if.req0_valid = tbl[i].v0; m_if.req0_data = tbl[i].d0;
            m_if.req1_valid = tbl[i].v1; m_if.req1_data = tbl[i].d1;
            #1;
            chk($sformatf("vec%0d", i), obs_m(), tbl[i].exp);
        end
        idle_all();

        // ---------------- reset in mid-frame ----------------
        do_reset();
        @(negedge clk);
        m_if.req0_valid = 1'b1; m_if.req0_data = 8'hFF;
        #1;
        chk("mid_accept", m_if.req0_ready, 1);
        repeat (4) begin
            @(negedge clk);
            m_if.req0_valid = 1'b0; m_if.req0_data = 8'h00;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ser_valid", m_if.ser_valid, 0);
        chk("mid_rst_done",      m_if.done,      0);
        chk("mid_rst_busy",      m_if.busy,      0);
        sv_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            if (m_if.ser_valid || m_if.busy || m_if.done) sv_cnt++;
        end
        chk("mid_no_leftover_bits", sv_cnt, 0);
        @(negedge clk);
        m_if.req0_valid = 1'b1; m_if.req0_data = 8'h01;
        #1;
        chk("mid_reaccept", m_if.req0_ready, 1);
        @(negedge clk);
        m_if.req0_valid = 1'b0; m_if.req0_data = 8'h00;
        #1;
        chk("mid_restart_bit0", {m_if.ser_valid, m_if.frame_start, m_if.ser_out}, 3'b111);
        @(negedge clk);
        #1;
        chk("mid_restart_bit1", {m_if.ser_valid, m_if.frame_start, m_if.ser_out}, 3'b100);

        // ---------------- MSB-first, 0x80 ----------------
        do_reset();
        @(negedge clk);
        msb_if.req0_valid = 1'b1; msb_if.req0_data = 8'h80;
        #1;
        chk("msb_accept", msb_if.req0_ready, 1);
        seq = 8'h00; nd = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            msb_if.req0_valid = 1'b0; msb_if.req0_data = 8'h00;
            #1;
            if (msb_if.ser_valid) seq = {seq[6:0], msb_if.ser_out};
            if (msb_if.done) nd++;
        end
        chk("msb_bit_sequence", seq, 8'h80);
        chk("msb_done_count", nd, 1);

        // ---------------- zero gap, req1 always valid ----------------
        do_reset();
        n_acc = 0; low = 0;
        for (int k = 0; k < 4; k++) acc_cyc[k] = -100;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                g0_if.req1_valid = 1'b1; g0_if.req1_data = 8'hC3;
            end
            #1;
            if (n_acc == 1 && !g0_if.busy) low++;
            if (g0_if.req1_ready) begin
                if (n_acc < 4) acc_cyc[n_acc] = c;
                n_acc++;
            end
        end
        idle_all();
        chk("gap0_spacing1", acc_cyc[1] - acc_cyc[0], 9);
        chk("gap0_spacing2", acc_cyc[2] - acc_cyc[1], 9);
        chk("gap0_idle_cycles", low, 1);
        chk("gap0_grant_id", g0_if.grant_id, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
